jimbo_mem_bridge: RTL and testbench

Memory-side stage directly downstream of the jimbo CPU pin interface (`tt_um_ringedSquid_top`). It owns a 2048×4 program/data RAM. It first streams a program into that RAM over a valid/ready load port while holding the CPU in reset. It then releases the CPU and services its 11-bit address, rw and 4-bit data bus. When the CPU touches the halt address, it freezes the CPU and exposes RAM through a debug read port for result checking.

---
 rtl/jimbo_mem_bridge.sv | 110 +++++++++++
 tb/tb_jimbo_mem_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jimbo_mem_bridge.sv
// Memory-side bridge for the jimbo CPU: streams a program into a 2048x4 RAM,
// runs the CPU against it, and freezes on the halt address for debug readout.
module jimbo_mem_bridge #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4,
    parameter logic [ADDR_W-1:0] HALT_ADDR = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [1:0]        state,
    output logic              halted,
    output logic [15:0]       run_cycles
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t            st;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ld_fire;
    logic              ptr_end;
    logic              cpu_wr;
    logic              cpu_halt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign state     = st;
    assign ld_fire   = (st == S_LOAD) && ld_valid && ld_ready;
    assign ptr_end   = (ptr == {ADDR_W{1'b1}});
    assign cpu_wr    = (st == S_RUN) && cpu_rw;
    assign cpu_halt  = (st == S_RUN) && (cpu_addr == HALT_ADDR);

    // A beat or CPU write coinciding with reset is dropped: reset wins.
    assign mem_we    = rst_n && (ld_fire || cpu_wr);
    assign mem_waddr = ld_fire ? ptr : cpu_addr;
    assign mem_wdata = ld_fire ? ld_data : cpu_wdata;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dbg_rdata = mem[dbg_addr];
    assign cpu_rdata = (st == S_RUN && !cpu_rw) ? mem[cpu_addr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= S_LOAD;
            ptr        <= '0;
            run_cycles <= '0;
            cpu_rst_n  <= 1'b0;
            halted     <= 1'b0;
            ld_ready   <= 1'b1;
        end else begin
            unique case (st)
                S_LOAD: begin
                    if (ld_fire) begin
                        ptr <= ptr + 1'b1;
                        // Last slot forces RUN so the pointer never wraps.
                        if (ld_last || ptr_end) begin
                            st        <= S_RUN;
                            ld_ready  <= 1'b0;
                            cpu_rst_n <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (cpu_halt) begin
                        st        <= S_HALT;
                        cpu_rst_n <= 1'b0;
                        halted    <= 1'b1;
                    end
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st        <= S_LOAD;
                    cpu_rst_n <= 1'b0;
                    halted    <= 1'b0;
                    ld_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jimbo_mem_bridge.sv
// Directed bench for jimbo_mem_bridge: vector table for RUN-mode bus traffic
// plus hand sequences for load, halt, full-depth load, reset and saturation.
module tb_jimbo_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_data;
    logic        ld_last;
    logic        cpu_rst_n;
    logic [10:0] cpu_addr;
    logic        cpu_rw;
    logic [3:0]  cpu_wdata;
    logic [3:0]  cpu_rdata;
    logic [10:0] dbg_addr;
    logic [3:0]  dbg_rdata;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] run_cycles;

    int n_vec = 0;
    int n_bad = 0;

    jimbo_mem_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .state      (state),
        .halted     (halted),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [10:0] addr;
        logic [3:0]  wdata;
        logic [10:0] dbg;
        logic [3:0]  exp_rdata;
        logic [3:0]  exp_dbg;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [10:0] a, input logic [3:0] exp,
                        input string name);
        dbg_addr = a;
        #1;
        chk(name, {12'd0, dbg_rdata}, {12'd0, exp});
    endtask

    initial begin
        vt[0] = '{1'b0, 11'h002, 4'h0, 11'h000, 4'h3, 4'hA};
        vt[1] = '{1'b0, 11'h000, 4'h0, 11'h001, 4'hA, 4'h5};
        vt[2] = '{1'b1, 11'h010, 4'h9, 11'h010, 4'h0, 4'h9};
        vt[3] = '{1'b0, 11'h010, 4'h0, 11'h003, 4'h9, 4'hF};
        vt[4] = '{1'b1, 11'h003, 4'h7, 11'h003, 4'h0, 4'h7};
        vt[5] = '{1'b0, 11'h003, 4'h0, 11'h002, 4'h7, 4'h3};
        vt[6] = '{1'b0, 11'h001, 4'h0, 11'h010, 4'h5, 4'h9};

        rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        cpu_addr = '0; cpu_rw = 1'b0; cpu_wdata = '0; dbg_addr = '0;
        tick();
        tick();
        chk("rst_state", {14'd0, state}, 16'd0);
        chk("rst_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_ld_ready", {15'd0, ld_ready}, 16'd1);
        chk("rst_run_cycles", run_cycles, 16'd0);

        // Short program load
        rst_n = 1'b1;
        begin
            logic [3:0] prog [4];
            prog[0] = 4'hA; prog[1] = 4'h5; prog[2] = 4'h3; prog[3] = 4'hF;
            for (int i = 0; i < 4; i++) begin
                ld_valid = 1'b1;
                ld_data  = prog[i];
                ld_last  = (i == 3);
                chk("load_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
                chk("load_cpu_rdata", {12'd0, cpu_rdata}, 16'd0);
                tick();
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("run_state", {14'd0, state}, 16'd1);
        chk("run_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd1);
        chk("run_ld_ready", {15'd0, ld_ready}, 16'd0);
        peek(11'h000, 4'hA, "mem0");
        peek(11'h001, 4'h5, "mem1");
        peek(11'h002, 4'h3, "mem2");
        peek(11'h003, 4'hF, "mem3");

        for (int i = 0; i < 7; i++) begin
            cpu_rw    = vt[i].rw;
            cpu_addr  = vt[i].addr;
            cpu_wdata = vt[i].wdata;
            #1;
            chk($sformatf("vec%0d_rdata", i), {12'd0, cpu_rdata},
                {12'd0, vt[i].exp_rdata});
            tick();
            peek(vt[i].dbg, vt[i].exp_dbg, $sformatf("vec%0d_dbg", i));
            chk($sformatf("vec%0d_state", i), {14'd0, state}, 16'd1);
        end
        chk("run_cycles_7", run_cycles, 16'd7);

        // Halt with a write to the halt address
        cpu_rw = 1'b1; cpu_addr = 11'h7FF; cpu_wdata = 4'hC;
        tick();
        chk("halt_state", {14'd0, state}, 16'd2);
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        chk("halt_run_cycles", run_cycles, 16'd8);
        peek(11'h7FF, 4'hC, "halt_mem7ff");
        cpu_rw = 1'b1; cpu_addr = 11'h000; cpu_wdata = 4'h1;
        tick();
        peek(11'h000, 4'hA, "halt_write_ignored");
        chk("halt_frozen_cycles", run_cycles, 16'd8);
        chk("halt_stays", {14'd0, state}, 16'd2);
        cpu_rw = 1'b0;
        #1;
        chk("halt_cpu_rdata", {12'd0, cpu_rdata}, 16'd0);

        // Full-depth load without ld_last
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cpu_addr = '0; cpu_rw = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            logic [10:0] iv;
            iv = 11'(i);
            if (i == 2047) begin
                chk("full_pre_state", {14'd0, state}, 16'd0);
            end
            ld_valid = 1'b1;
            ld_data  = iv[3:0] ^ 4'h5;
            ld_last  = 1'b0;
            tick();
        end
        chk("full_state", {14'd0, state}, 16'd1);
        chk("full_ld_ready", {15'd0, ld_ready}, 16'd0);
        peek(11'h7FF, 4'hA, "full_mem7ff");
        peek(11'h100, 4'h5, "full_mem100");
        ld_data = 4'hE;
        tick();
        ld_valid = 1'b0;
        peek(11'h000, 4'h5, "ld_ignored_run");
        for (int i = 0; i < 99; i++) tick();
        chk("run_cycles_100", run_cycles, 16'd100);

        // Mid-run reset preserves RAM, reload restarts at 0
        rst_n = 1'b0;
        tick();
        chk("mrst_state", {14'd0, state}, 16'd0);
        chk("mrst_cycles", run_cycles, 16'd0);
        chk("mrst_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        chk("mrst_ld_ready", {15'd0, ld_ready}, 16'd1);
        peek(11'h7FF, 4'hA, "mrst_mem7ff");
        peek(11'h123, 4'h6, "mrst_mem123");
        rst_n = 1'b1;
        ld_valid = 1'b1; ld_data = 4'hE; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        peek(11'h000, 4'hE, "reload_mem0");
        peek(11'h001, 4'h4, "reload_mem1");
        chk("reload_state", {14'd0, state}, 16'd1);

        // Saturation
        for (int i = 0; i < 65535; i++) tick();
        chk("sat_edge", run_cycles, 16'hFFFF);
        for (int i = 0; i < 4465; i++) tick();
        chk("sat_hold", run_cycles, 16'hFFFF);
        chk("sat_state", {14'd0, state}, 16'd1);

        // Reset wins over a simultaneous halt
        rst_n = 1'b0; cpu_addr = 11'h7FF; cpu_rw = 1'b1; cpu_wdata = 4'h2;
        tick();
        chk("rwin_halt_state", {14'd0, state}, 16'd0);
        chk("rwin_halt_halted", {15'd0, halted}, 16'd0);
        cpu_addr = '0; cpu_rw = 1'b0;
        // Reset wins over a simultaneous last beat
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 4'h3;
        tick();
        chk("rwin_ld_state", {14'd0, state}, 16'd0);
        chk("rwin_ld_ready", {15'd0, ld_ready}, 16'd1);
        ld_valid = 1'b0; ld_last = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
